// File: rtl/dmem_lsu_pkg.sv
// Shared types, funct3 codes and helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 16;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned LANES          = 4;

    // RISC-V load/store size encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RESP       = 2'd1,
        ST_SPLIT2     = 2'd2,
        ST_SPLIT_RESP = 2'd3
    } state_t;

    // Second-word (B side) memory cycle of a split access
    typedef struct packed {
        logic [XLEN-1:0]  addr;
        logic [LANES-1:0] we;
        logic [XLEN-1:0]  wdata;
    } mem_req_t;

    // Lane enable pattern for an access at offset 0
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3)
            F3_B, F3_BU: m = 4'b0001;
            F3_H, F3_HU: m = 4'b0011;
            F3_W:        m = 4'b1111;
            default:     m = 4'b0000;
        endcase
        return m;
    endfunction

    // Reserved encodings, and unsigned variants that have no store form
    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment: store enable/data shift-up and load shift-down plus extension.
module dmem_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [63:0] i_data,
    output logic [7:0]  o_mask,
    output logic [63:0] o_sdata,
    output logic [31:0] o_ldata
);

    logic [4:0]  w_sh;
    logic [31:0] w_r32;

    assign w_sh    = {i_off, 3'b000};
    assign o_mask  = {4'b0000, size_mask(i_funct3)} << i_off;
    assign o_sdata = {32'h0, i_data[31:0]} << w_sh;
    assign w_r32   = 32'(i_data >> w_sh);

    // Extract the addressed bytes and sign/zero-extend to 32 bits
    always_comb begin
        o_ldata = w_r32;
        case (i_funct3)
            F3_B:    o_ldata = {{24{w_r32[7]}}, w_r32[7:0]};
            F3_BU:   o_ldata = {24'h0, w_r32[7:0]};
            F3_H:    o_ldata = {{16{w_r32[15]}}, w_r32[15:0]};
            F3_HU:   o_ldata = {16'h0, w_r32[15:0]};
            default: o_ldata = w_r32;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: aligns stores to four byte-lane banks, formats loads and
// splits word-crossing accesses into two aligned memory cycles.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
)
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic        o_resp_err,
    output logic [31:0] o_resp_rdata,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_we,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    // Address bits the banks decode; B-word increment wraps inside this field
    localparam logic [31:0] AMASK = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                  : 32'((64'd1 << ADDR_WIDTH) - 64'd1);

    state_t      r_state;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_is_load;
    mem_req_t    r_b;
    logic [31:0] r_hold;

    logic        w_accept;
    logic        w_illegal;
    logic        w_split;
    logic [31:0] w_a_addr;
    logic [31:0] w_b_addr;
    logic [7:0]  w_st_mask;
    logic [63:0] w_st_sdata;
    logic [31:0] w_st_ldata;
    logic [63:0] w_ld_in;
    logic [7:0]  w_ld_mask;
    logic [63:0] w_ld_sdata;
    logic [31:0] w_ld_data;
    logic        w_unused;

    assign o_req_ready = (r_state != ST_SPLIT2);
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_illegal   = is_illegal(i_req_we, i_req_funct3);
    assign w_split     = (|w_st_mask[7:4]) && !w_illegal;
    assign w_a_addr    = {i_req_addr[31:2], 2'b00};
    assign w_b_addr    = (w_a_addr & ~AMASK) | ((w_a_addr + 32'd4) & AMASK);

    // Split loads combine the held A word with the B word now on the bus
    assign w_ld_in = (r_state == ST_SPLIT_RESP) ? {i_mem_rdata, r_hold}
                                                : {32'h0, i_mem_rdata};

    // Store direction: request offset/size drive lane enables and data
    dmem_lane_align u_st_align (
        .i_funct3 (i_req_funct3),
        .i_off    (i_req_addr[1:0]),
        .i_data   ({32'h0, i_req_wdata}),
        .o_mask   (w_st_mask),
        .o_sdata  (w_st_sdata),
        .o_ldata  (w_st_ldata)
    );

    // Load direction: registered offset/size format the returning lanes
    dmem_lane_align u_ld_align (
        .i_funct3 (r_funct3),
        .i_off    (r_off),
        .i_data   (w_ld_in),
        .o_mask   (w_ld_mask),
        .o_sdata  (w_ld_sdata),
        .o_ldata  (w_ld_data)
    );

    // Each direction only needs half of the aligner's outputs
    assign w_unused = ^{w_st_ldata, w_ld_mask, w_ld_sdata};

    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_resp_rdata = (r_resp_valid && !r_resp_err) ? w_ld_data : 32'h0;

    // Memory port: B-side registers in SPLIT2, otherwise the incoming request
    always_comb begin
        o_mem_addr  = w_a_addr;
        o_mem_we    = 4'b0000;
        o_mem_wdata = w_st_sdata[31:0];
        if (r_state == ST_SPLIT2) begin
            o_mem_addr  = r_b.addr;
            o_mem_we    = r_b.we;
            o_mem_wdata = r_b.wdata;
        end else if (w_accept && i_req_we && !w_illegal) begin
            o_mem_we    = w_st_mask[3:0];
        end
    end

    // Access sequencing FSM with request, B-side and hold registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_funct3     <= 3'b000;
            r_off        <= 2'b00;
            r_is_load    <= 1'b0;
            r_b          <= '0;
            r_hold       <= 32'h0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                ST_SPLIT2: begin
                    r_hold <= i_mem_rdata;
                    if (r_is_load) begin
                        r_state      <= ST_SPLIT_RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    if (w_accept) begin
                        r_funct3  <= i_req_funct3;
                        r_off     <= i_req_addr[1:0];
                        r_is_load <= !i_req_we;
                        if (w_illegal) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (w_split) begin
                            r_state     <= ST_SPLIT2;
                            r_b.addr    <= w_b_addr;
                            r_b.we      <= i_req_we ? w_st_mask[7:4] : 4'b0000;
                            r_b.wdata   <= w_st_sdata[63:32];
                        end else if (!i_req_we) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
